reorder_commit_stage: RTL and testbench
=======================================

// Module: reorder_commit_stage
// PURPOSE
//  Parametrised in-order commit stage: accepts results tagged with commit_id in any order and
//  releases them strictly in ascending (modulo 2^commit_id_width) commit_id order.
//  Sits between the out-of-order block execution units and the register/channel writeback.
//  Adds a reorder window, duplicate/stale detection, optional drop of non-committing entries and flush.
// PARAMETERS
//  data_width       16                  result is 2*data_width bits, signed
//  n_blocks         256                 block index width = $clog2(n_blocks)
//  commit_id_width  `COMMIT_ID_WIDTH    tag width (9)
//  depth            8                   reorder slots; power of 2, <= 2^(commit_id_width-1)
//  drop_nocommit    0                   1: entries with commit_flag=0 retire internally, never output
// PORTS
//  clk              in   1      clock
//  reset            in   1      synchronous, active-high
//  enable           in   1      0 = freeze all state
//  flush            in   1      clear window, restart at flush_id
//  flush_id         in   CIW    new head_id on flush
//  in_valid/in_ready  in/out 1  input handshake
//  block_in         in   $clog2(n_blocks)
//  result_in        in   2*data_width  signed
//  dest_in          in   4
//  commit_id_in     in   CIW
//  commit_flag_in   in   1
//  out_valid/out_ready out/in 1 output handshake
//  block_out, result_out, dest_out, commit_id_out, commit_flag_out  out  (widths as inputs)
//  dup_err          out  1      1-cycle pulse: in-window id whose slot already occupied
//  stale_err        out  1      1-cycle pulse: id behind head_id
//  occupancy        out  $clog2(depth)+1  occupied slots (excl. output register)
// BEHAVIOUR
//  - Reset: head_id=0, all slots empty, out_valid=0, all payload outputs 0, errs 0, occupancy 0.
//  - dist = (commit_id_in - head_id) mod 2^CIW; slot index = commit_id_in[log2(depth)-1:0].
//  - in_ready = enable & ~flush & ~(dist >= depth & dist < 2^(CIW-1)); may depend on commit_id_in,
//    so source must hold payload stable while in_valid=1.
//  - Fire, dist < depth, slot empty: write slot, mark valid.
//  - Fire, dist < depth, slot occupied: entry dropped, dup_err=1 next cycle.
//  - Fire, dist >= 2^(CIW-1) (stale): dropped, stale_err=1 next cycle.
//  - Output register loads when enable & (~out_valid | out_ready) & head entry present; head_id++,
//    slot cleared. Max one retire per cycle; head_id wraps mod 2^CIW.
//  - Bypass: fire with dist==0 and output loadable -> straight into output reg; latency 1 cycle.
//    Otherwise latency = cycles until head present + 1.
//  - drop_nocommit=1: head entry with commit_flag=0 retires (head_id++) without loading output,
//    one per cycle, even when out_valid & ~out_ready.
//  - Simultaneous fire into slot being retired same cycle: impossible (retire is dist 0, new entry
//    at same index would have dist=depth -> stalled).
//  - out_valid once high holds with stable payload until out_ready (except flush/reset).
//  - flush (needs enable): highest priority after reset; clears slots and out_valid,
//    head_id<=flush_id, errs 0, input not accepted that cycle.
//  - enable=0: no state change, in_ready=0, outputs held, err pulses 0.
//  - occupancy updates registered: +1 on slot write, -1 on retire, both -> unchanged.
// STRUCTURE
//  - Shared package: payload_width localparam/function, payload field order
//    {block, result, dest, commit_id, commit_flag}, commit_id_dist() helper.
//  - Sub-module reorder_slot_ram: depth x payload_width regs + valid bits, one write, one read/clear.
//  - Top: head_id counter, window check, retire/output register, error pulses.
// TESTING
//  - In-order ids 0..7 back-to-back, out_ready=1 -> out ids 0..7, each 1 cycle after accept.
//  - ids 3,1,2,0 -> no out_valid until 0 accepted; then out 0,1,2,3 on consecutive cycles.
//  - head=0, send id 8 (depth 8) -> in_ready=0 until id 0 retires; then accepted.
//  - id 5 twice -> second dropped, dup_err pulse; id 511 at head=0 -> stale_err pulse.
//  - drop_nocommit=1, ids 0(flag0),1(flag1) -> only id 1 output; head_id=2.
//  - head=510, ids 510,511,0,1 with out_ready toggling; then flush flush_id=40 mid-stream
//    -> wrap order kept, payload stable under stall, post-flush empty and head=40.

Source files
------------

// File: rtl/reorder_commit_stage_pkg.sv
// Shared definitions for the in-order commit stage.
//  - payload_width(): total bits of one stored entry
//  - commit_id_dist(): modular distance of an id ahead of the head id
// Payload field order, MSB to LSB: {block, result, dest, commit_id, commit_flag}.
`ifndef COMMIT_ID_WIDTH
`define COMMIT_ID_WIDTH 9
`endif

package reorder_commit_stage_pkg;

    localparam int DEST_WIDTH = 4;

    function automatic int payload_width(input int block_w, input int data_w, input int ciw);
        return block_w + 2 * data_w + DEST_WIDTH + ciw + 1;
    endfunction

    // Distance of id ahead of head, modulo 2^ciw
    function automatic logic [31:0] commit_id_dist(input logic [31:0] id, input logic [31:0] head,
                                                   input int ciw);
        logic [31:0] mask_v;
        mask_v = (32'd1 << ciw) - 32'd1;
        return (id - head) & mask_v;
    endfunction

endpackage

// File: rtl/reorder_commit_stage_slot_ram.sv
// Reorder slot storage: depth entries of payload plus a valid bit each.
// Ports: clk/reset; clear_all empties every slot; wr_en/wr_idx/wr_data fill a slot;
// clr_en empties slot rd_idx; rd_idx/rd_data/rd_valid read the head slot;
// chk_idx/chk_valid report whether the slot an incoming id maps to is occupied.
module reorder_slot_ram #(
    parameter int depth = 8,
    parameter int width = 54
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clear_all,
    input  logic                     wr_en,
    input  logic [$clog2(depth)-1:0] wr_idx,
    input  logic [width-1:0]         wr_data,
    input  logic                     clr_en,
    input  logic [$clog2(depth)-1:0] rd_idx,
    output logic [width-1:0]         rd_data,
    output logic                     rd_valid,
    input  logic [$clog2(depth)-1:0] chk_idx,
    output logic                     chk_valid
);

    logic [depth-1:0] valid_r;
    logic [width-1:0] data_r [depth];

    assign rd_data   = data_r[rd_idx];
    assign rd_valid  = valid_r[rd_idx];
    assign chk_valid = valid_r[chk_idx];

    // Slot valid bits: set on write, cleared on retire or flush
    always_ff @(posedge clk) begin
        if (reset || clear_all) begin
            valid_r <= '0;
        end else begin
            if (clr_en) valid_r[rd_idx] <= 1'b0;
            if (wr_en)  valid_r[wr_idx] <= 1'b1;
        end
    end

    // Slot payload storage; contents only meaningful while the valid bit is set
    always_ff @(posedge clk) begin
        if (wr_en) data_r[wr_idx] <= wr_data;
    end

endmodule

// File: rtl/reorder_commit_stage.sv
// In-order commit stage: accepts tagged results in any order and releases them in ascending
// (modulo 2^commit_id_width) commit_id order through a registered output.
// Ports: clk/reset (sync, active-high); enable freezes all state; flush/flush_id restart the
// window; in_* handshake with payload; out_* handshake with registered payload;
// dup_err/stale_err one-cycle error pulses; occupancy = occupied reorder slots.
module reorder_commit_stage
    import reorder_commit_stage_pkg::*;
#(
    parameter int data_width      = 16,
    parameter int n_blocks        = 256,
    parameter int commit_id_width = `COMMIT_ID_WIDTH,
    parameter int depth           = 8,
    parameter bit drop_nocommit   = 1'b0
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               enable,
    input  logic                               flush,
    input  logic [commit_id_width-1:0]         flush_id,
    input  logic                               in_valid,
    output logic                               in_ready,
    input  logic [$clog2(n_blocks)-1:0]        block_in,
    input  logic signed [2*data_width-1:0]     result_in,
    input  logic [3:0]                         dest_in,
    input  logic [commit_id_width-1:0]         commit_id_in,
    input  logic                               commit_flag_in,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic [$clog2(n_blocks)-1:0]        block_out,
    output logic signed [2*data_width-1:0]     result_out,
    output logic [3:0]                         dest_out,
    output logic [commit_id_width-1:0]         commit_id_out,
    output logic                               commit_flag_out,
    output logic                               dup_err,
    output logic                               stale_err,
    output logic [$clog2(depth):0]             occupancy
);

    localparam int CIW = commit_id_width;
    localparam int BW  = $clog2(n_blocks);
    localparam int RW  = 2 * data_width;
    localparam int AW  = $clog2(depth);
    localparam int OW  = AW + 1;
    localparam int PW  = payload_width(BW, data_width, CIW);
    // Field offsets inside the packed payload
    localparam int ID_LO  = 1;
    localparam int DST_LO = ID_LO + CIW;
    localparam int RES_LO = DST_LO + DEST_WIDTH;
    localparam int BLK_LO = RES_LO + RW;

    logic [CIW-1:0] head_id_r;
    logic           out_valid_r;
    logic [PW-1:0]  out_payload_r;
    logic           dup_err_r;
    logic           stale_err_r;
    logic [OW-1:0]  occupancy_r;

    logic [CIW-1:0] dist_s;
    logic           in_window_s;
    logic           stale_s;
    logic           fire_s;
    logic           loadable_s;
    logic [PW-1:0]  in_payload_s;
    logic [PW-1:0]  head_payload_s;
    logic           head_valid_s;
    logic           wr_occupied_s;
    logic           wr_en_s;
    logic           clr_en_s;
    logic           load_s;
    logic           load_sel_in_s;
    logic           adv_s;
    logic           dup_s;
    logic           stale_hit_s;

    assign dist_s       = CIW'(commit_id_dist(32'(commit_id_in), 32'(head_id_r), CIW));
    assign in_window_s  = (dist_s < CIW'(depth));
    // Upper half of the id space counts as "behind" the head
    assign stale_s      = dist_s[CIW-1];
    // Ids between the window end and the stale half wait until the window advances
    assign in_ready     = enable & ~flush & (in_window_s | stale_s);
    assign fire_s       = in_valid & in_ready;
    assign loadable_s   = ~out_valid_r | out_ready;
    assign in_payload_s = {block_in, result_in, dest_in, commit_id_in, commit_flag_in};

    reorder_slot_ram #(
        .depth (depth),
        .width (PW)
    ) u_slot_ram (
        .clk       (clk),
        .reset     (reset),
        .clear_all (enable & flush),
        .wr_en     (wr_en_s),
        .wr_idx    (commit_id_in[AW-1:0]),
        .wr_data   (in_payload_s),
        .clr_en    (clr_en_s),
        .rd_idx    (head_id_r[AW-1:0]),
        .rd_data   (head_payload_s),
        .rd_valid  (head_valid_s),
        .chk_idx   (commit_id_in[AW-1:0]),
        .chk_valid (wr_occupied_s)
    );

    // Retire / accept decisions for this cycle
    always_comb begin
        wr_en_s       = 1'b0;
        clr_en_s      = 1'b0;
        load_s        = 1'b0;
        load_sel_in_s = 1'b0;
        adv_s         = 1'b0;
        dup_s         = 1'b0;
        stale_hit_s   = 1'b0;
        if (enable && !flush) begin
            // A stored head entry retires; non-committing ones may skip the output register
            if (head_valid_s) begin
                if (drop_nocommit && !head_payload_s[0]) begin
                    clr_en_s = 1'b1;
                    adv_s    = 1'b1;
                end else if (loadable_s) begin
                    clr_en_s = 1'b1;
                    adv_s    = 1'b1;
                    load_s   = 1'b1;
                end else begin
                    clr_en_s = 1'b0;
                end
            end else begin
                clr_en_s = 1'b0;
            end
            // Incoming entry; dist==0 with an empty head slot may bypass storage entirely
            if (fire_s) begin
                if (stale_s) begin
                    stale_hit_s = 1'b1;
                end else if (wr_occupied_s) begin
                    dup_s = 1'b1;
                end else if (dist_s == {CIW{1'b0}} && drop_nocommit && !commit_flag_in) begin
                    adv_s = 1'b1;
                end else if (dist_s == {CIW{1'b0}} && loadable_s) begin
                    adv_s         = 1'b1;
                    load_s        = 1'b1;
                    load_sel_in_s = 1'b1;
                end else begin
                    wr_en_s = 1'b1;
                end
            end else begin
                wr_en_s = 1'b0;
            end
        end else begin
            wr_en_s = 1'b0;
        end
    end

    // Head pointer, output register, error pulses and occupancy count
    always_ff @(posedge clk) begin
        if (reset) begin
            head_id_r     <= '0;
            out_valid_r   <= 1'b0;
            out_payload_r <= '0;
            dup_err_r     <= 1'b0;
            stale_err_r   <= 1'b0;
            occupancy_r   <= '0;
        end else if (enable) begin
            if (flush) begin
                head_id_r   <= flush_id;
                out_valid_r <= 1'b0;
                dup_err_r   <= 1'b0;
                stale_err_r <= 1'b0;
                occupancy_r <= '0;
            end else begin
                if (adv_s) head_id_r <= head_id_r + CIW'(1'b1);
                if (load_s) begin
                    out_valid_r   <= 1'b1;
                    out_payload_r <= load_sel_in_s ? in_payload_s : head_payload_s;
                end else if (out_ready) begin
                    out_valid_r <= 1'b0;
                end
                dup_err_r   <= dup_s;
                stale_err_r <= stale_hit_s;
                case ({wr_en_s, clr_en_s})
                    2'b10:   occupancy_r <= occupancy_r + OW'(1'b1);
                    2'b01:   occupancy_r <= occupancy_r - OW'(1'b1);
                    default: occupancy_r <= occupancy_r;
                endcase
            end
        end else begin
            dup_err_r   <= 1'b0;
            stale_err_r <= 1'b0;
        end
    end

    assign out_valid       = out_valid_r;
    assign commit_flag_out = out_payload_r[0];
    assign commit_id_out   = out_payload_r[DST_LO-1:ID_LO];
    assign dest_out        = out_payload_r[RES_LO-1:DST_LO];
    assign result_out      = out_payload_r[BLK_LO-1:RES_LO];
    assign block_out       = out_payload_r[PW-1:BLK_LO];
    assign dup_err         = dup_err_r;
    assign stale_err       = stale_err_r;
    assign occupancy       = occupancy_r;

endmodule

// File: tb/tb_reorder_commit_stage.sv
// Bench for reorder_commit_stage: directed scenarios plus a random phase, every cycle compared
// against an id-indexed reference model; a second instance exercises drop_nocommit=1.
module tb_reorder_commit_stage;

    typedef struct packed {
        logic [7:0]  blk;
        logic [31:0] res;
        logic [3:0]  dst;
        logic [8:0]  id;
        logic        flg;
    } pay_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, enable, flush, in_valid, commit_flag_in, out_ready;
    logic [8:0]  flush_id, commit_id_in;
    logic [7:0]  block_in;
    logic [31:0] result_in;
    logic [3:0]  dest_in;
    logic        in_ready, out_valid, commit_flag_out, dup_err, stale_err;
    logic [7:0]  block_out;
    logic [31:0] result_out;
    logic [3:0]  dest_out;
    logic [8:0]  commit_id_out;
    logic [3:0]  occupancy;

    // second instance (drop_nocommit = 1)
    logic        in2_valid, flag2_in, out2_ready;
    logic [8:0]  id2_in;
    logic        in2_ready, out2_valid, flag2_out, dup2_err, stale2_err;
    logic [7:0]  block2_out;
    logic [31:0] result2_out;
    logic [3:0]  dest2_out;
    logic [8:0]  id2_out;
    logic [3:0]  occupancy2;

    reorder_commit_stage #(.data_width(16), .n_blocks(256), .commit_id_width(9), .depth(8),
                           .drop_nocommit(1'b0)) dut (
        .clk(clk), .reset(reset), .enable(enable), .flush(flush), .flush_id(flush_id),
        .in_valid(in_valid), .in_ready(in_ready), .block_in(block_in), .result_in(result_in),
        .dest_in(dest_in), .commit_id_in(commit_id_in), .commit_flag_in(commit_flag_in),
        .out_valid(out_valid), .out_ready(out_ready), .block_out(block_out),
        .result_out(result_out), .dest_out(dest_out), .commit_id_out(commit_id_out),
        .commit_flag_out(commit_flag_out), .dup_err(dup_err), .stale_err(stale_err),
        .occupancy(occupancy));

    reorder_commit_stage #(.data_width(16), .n_blocks(256), .commit_id_width(9), .depth(8),
                           .drop_nocommit(1'b1)) dut_drop (
        .clk(clk), .reset(reset), .enable(1'b1), .flush(1'b0), .flush_id(9'd0),
        .in_valid(in2_valid), .in_ready(in2_ready), .block_in(8'h5a), .result_in(32'h1234),
        .dest_in(4'h3), .commit_id_in(id2_in), .commit_flag_in(flag2_in),
        .out_valid(out2_valid), .out_ready(out2_ready), .block_out(block2_out),
        .result_out(result2_out), .dest_out(dest2_out), .commit_id_out(id2_out),
        .commit_flag_out(flag2_out), .dup_err(dup2_err), .stale_err(stale2_err),
        .occupancy(occupancy2));

    int checks = 0;
    int fails  = 0;

    // reference model: entries kept by full commit id
    bit   m_have [512];
    pay_t m_pay  [512];
    int   m_head;
    bit   m_ov, m_dup, m_stale;
    pay_t m_out;

    int q1[$];
    int q2[$];

    // consumer-side record of completed output transfers
    always @(negedge clk) begin
        if (!reset && enable && !flush && out_valid && out_ready) q1.push_back(int'(commit_id_out));
        if (!reset && out2_valid && out2_ready) q2.push_back(int'(id2_out));
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int mdist(input int id);
        return (id - m_head) & 511;
    endfunction

    function automatic bit mready();
        int d;
        d = mdist(int'(commit_id_in));
        return enable && !flush && !(d >= 8 && d < 256);
    endfunction

    function automatic int mocc();
        int n = 0;
        for (int i = 0; i < 512; i++) n += int'(m_have[i]);
        return n;
    endfunction

    task automatic model_step();
        int d, id, oh;
        bit fire, head_here, id_here, loadable;
        pay_t p;
        if (reset) begin
            for (int i = 0; i < 512; i++) m_have[i] = 1'b0;
            m_head = 0; m_ov = 1'b0; m_out = '0; m_dup = 1'b0; m_stale = 1'b0;
        end else if (!enable) begin
            m_dup = 1'b0; m_stale = 1'b0;
        end else if (flush) begin
            for (int i = 0; i < 512; i++) m_have[i] = 1'b0;
            m_head = int'(flush_id); m_ov = 1'b0; m_dup = 1'b0; m_stale = 1'b0;
        end else begin
            id = int'(commit_id_in);
            d = mdist(id);
            fire = in_valid && mready();
            oh = m_head;
            head_here = m_have[oh];
            id_here = m_have[id];
            loadable = !m_ov || out_ready;
            p = '{blk: block_in, res: result_in, dst: dest_in, id: commit_id_in, flg: commit_flag_in};
            m_dup = 1'b0; m_stale = 1'b0;
            if (m_ov && out_ready) m_ov = 1'b0;
            if (head_here && loadable) begin
                m_out = m_pay[oh]; m_ov = 1'b1; m_have[oh] = 1'b0; m_head = (oh + 1) & 511;
            end
            if (fire) begin
                if (d >= 256) m_stale = 1'b1;
                else if (id_here) m_dup = 1'b1;
                else if (d == 0 && loadable) begin
                    m_out = p; m_ov = 1'b1; m_head = (oh + 1) & 511;
                end else begin
                    m_have[id] = 1'b1; m_pay[id] = p;
                end
            end
        end
    endtask

    // one clock: check in_ready, advance model, compare registered outputs after the edge
    task automatic tick(output bit acc);
        #1;
        acc = in_valid && mready();
        if (!reset) chk("in_ready", 64'(in_ready), 64'(mready()));
        model_step();
        @(posedge clk);
        #1;
        chk("out_valid", 64'(out_valid), 64'(m_ov));
        chk("payload", 64'({block_out, result_out, dest_out, commit_id_out, commit_flag_out}),
            64'(m_out));
        chk("dup_err", 64'(dup_err), 64'(m_dup));
        chk("stale_err", 64'(stale_err), 64'(m_stale));
        chk("occupancy", 64'(occupancy), 64'(mocc()));
    endtask

    task automatic send(input int id, input bit flag, output bit acc);
        in_valid = 1'b1;
        commit_id_in = 9'(id);
        commit_flag_in = flag;
        block_in = 8'($urandom);
        result_in = $urandom;
        dest_in = 4'($urandom);
        tick(acc);
    endtask

    task automatic idle(input int n);
        bit a;
        in_valid = 1'b0;
        for (int i = 0; i < n; i++) tick(a);
    endtask

    task automatic send2(input int id, input bit flag);
        in2_valid = 1'b1; id2_in = 9'(id); flag2_in = flag;
        idle(1);
        in2_valid = 1'b0;
    endtask

    initial begin
        bit acc, holding;
        int hold_cnt, r, sel;
        logic [53:0] held;

        reset = 1'b1; enable = 1'b1; flush = 1'b0; flush_id = 9'd0; in_valid = 1'b0;
        commit_id_in = 9'd0; commit_flag_in = 1'b1; block_in = 8'd0; result_in = 32'd0;
        dest_in = 4'd0; out_ready = 1'b1;
        in2_valid = 1'b0; id2_in = 9'd0; flag2_in = 1'b1; out2_ready = 1'b1;
        idle(2);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_occupancy", 64'(occupancy), 64'd0);
        chk("rst_result", 64'(result_out), 64'd0);
        reset = 1'b0;

        // in-order ids, one cycle latency each
        for (int i = 0; i < 8; i++) begin
            send(i, 1'b1, acc);
            chk("inorder_acc", 64'(acc), 64'd1);
            chk("inorder_id", 64'(commit_id_out), 64'(i));
        end

        // out of order: 11,9,10 wait for 8
        send(11, 1'b1, acc); chk("ooo_wait", 64'(out_valid), 64'd0);
        send(9, 1'b1, acc);  chk("ooo_wait", 64'(out_valid), 64'd0);
        send(10, 1'b1, acc); chk("ooo_wait", 64'(out_valid), 64'd0);
        send(8, 1'b1, acc);  chk("ooo_id", 64'(commit_id_out), 64'd8);
        in_valid = 1'b0;
        for (int i = 9; i < 12; i++) begin
            idle(1);
            chk("ooo_id", 64'(commit_id_out), 64'(i));
        end

        // window: head 12, id 20 is one past the window
        send(20, 1'b1, acc); chk("win_block", 64'(acc), 64'd0);
        send(20, 1'b1, acc); chk("win_block", 64'(acc), 64'd0);
        send(12, 1'b1, acc); chk("win_head", 64'(commit_id_out), 64'd12);
        send(20, 1'b1, acc); chk("win_accept", 64'(acc), 64'd1);
        for (int i = 13; i < 20; i++) send(i, 1'b1, acc);
        idle(2);
        chk("win_drain", 64'(commit_id_out), 64'd20);

        // duplicate and stale detection (head 21)
        send(26, 1'b1, acc); chk("dup_first", 64'(dup_err), 64'd0);
        send(26, 1'b1, acc); chk("dup_second", 64'(dup_err), 64'd1);
        idle(1);             chk("dup_pulse_end", 64'(dup_err), 64'd0);
        send(20, 1'b1, acc); chk("stale_pulse", 64'(stale_err), 64'd1);
        for (int i = 21; i < 26; i++) send(i, 1'b1, acc);
        idle(2);

        // wrap around 511 -> 0 with a toggling consumer
        flush = 1'b1; flush_id = 9'd510; idle(1); flush = 1'b0;
        q1.delete();
        out_ready = 1'b0; send(511, 1'b1, acc);
        out_ready = 1'b1; send(510, 1'b1, acc);
        out_ready = 1'b0; send(0, 1'b1, acc);
        out_ready = 1'b1; send(1, 1'b1, acc);
        in_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            out_ready = ~out_ready;
            held = {block_out, result_out, dest_out, commit_id_out, commit_flag_out};
            r = int'(out_valid && !out_ready);
            idle(1);
            if (r != 0) chk("stall_stable", 64'({block_out, result_out, dest_out, commit_id_out,
                                                commit_flag_out}), 64'(held));
        end
        chk("wrap_count", 64'(q1.size()), 64'd4);
        if (q1.size() == 4) begin
            chk("wrap_0", 64'(q1[0]), 64'd510);
            chk("wrap_1", 64'(q1[1]), 64'd511);
            chk("wrap_2", 64'(q1[2]), 64'd0);
            chk("wrap_3", 64'(q1[3]), 64'd1);
        end

        // flush mid-stream
        out_ready = 1'b1;
        send(3, 1'b1, acc); send(4, 1'b1, acc);
        flush = 1'b1; flush_id = 9'd40;
        send(5, 1'b1, acc); chk("flush_no_accept", 64'(acc), 64'd0);
        flush = 1'b0;
        chk("flush_out_valid", 64'(out_valid), 64'd0);
        chk("flush_occupancy", 64'(occupancy), 64'd0);
        send(40, 1'b1, acc);
        chk("flush_head", 64'(commit_id_out), 64'd40);
        chk("flush_head_v", 64'(out_valid), 64'd1);
        idle(2);

        // random phase
        holding = 1'b0; hold_cnt = 0;
        for (int c = 0; c < 600; c++) begin
            if (!holding) begin
                in_valid = ($urandom % 4) != 0;
                sel = int'($urandom % 16);
                if (sel < 12)      r = int'($urandom_range(0, 7));
                else if (sel < 14) r = int'($urandom_range(8, 11));
                else               r = int'($urandom_range(256, 511));
                commit_id_in = 9'((m_head + r) & 511);
                commit_flag_in = 1'($urandom);
                block_in = 8'($urandom); result_in = $urandom; dest_in = 4'($urandom);
            end
            enable = ($urandom % 16) != 0;
            flush = ($urandom % 64) == 0;
            flush_id = 9'($urandom);
            out_ready = ($urandom % 3) != 0;
            tick(acc);
            if (in_valid && !acc && hold_cnt < 4) begin
                holding = 1'b1; hold_cnt++;
            end else begin
                holding = 1'b0; hold_cnt = 0;
            end
        end
        enable = 1'b1; flush = 1'b0; out_ready = 1'b1;
        idle(3);

        // drop_nocommit instance
        q2.delete();
        send2(0, 1'b0);
        send2(1, 1'b1);
        id2_in = 9'd10; #1;
        chk("drop_win_block", 64'(in2_ready), 64'd0);
        id2_in = 9'd9; #1;
        chk("drop_win_open", 64'(in2_ready), 64'd1);
        send2(2, 1'b1);
        out2_ready = 1'b0;
        send2(4, 1'b0);
        send2(5, 1'b1);
        send2(3, 1'b0);
        idle(1);
        chk("drop_stall_occ", 64'(occupancy2), 64'd1);
        chk("drop_stall_hold", 64'(id2_out), 64'd2);
        out2_ready = 1'b1;
        idle(4);
        chk("drop_count", 64'(q2.size()), 64'd3);
        if (q2.size() == 3) begin
            chk("drop_out_0", 64'(q2[0]), 64'd1);
            chk("drop_out_1", 64'(q2[1]), 64'd2);
            chk("drop_out_2", 64'(q2[2]), 64'd5);
        end
        chk("drop_final_occ", 64'(occupancy2), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
